// File: rtl/cheri_pkg.sv
// cheri_pkg: shared types for the CHERI load/store arbitration slice.
//   arb_fsm_t  - arbiter ownership state encoding
//   arb_tag_t  - per-request owner tag kept until the LSU response returns
package cheri_pkg;

    typedef logic [1:0] arb_fsm_t;

    localparam arb_fsm_t ARB_IDLE = 2'd0;
    localparam arb_fsm_t ARB_CORE = 2'd1;
    localparam arb_fsm_t ARB_TBRE = 2'd2;

    typedef struct packed {
        logic owner_tbre;
        logic we;
    } arb_tag_t;

endpackage

// File: rtl/cheri_arb_tag_fifo.sv
// cheri_arb_tag_fifo: Depth-entry synchronous FIFO of arb_tag_t owner tags.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   push_i, data_i  - write a tag (accepted when not full, or when popping)
//   pop_i           - drop the head entry (ignored when empty)
//   full_o, empty_o - occupancy flags
//   head_o          - oldest entry
import cheri_pkg::*;

module cheri_arb_tag_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  arb_tag_t data_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output arb_tag_t head_o
);

    localparam int unsigned AW = $clog2(Depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    arb_tag_t    mem_q [Depth];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/cheri_lsu_arb.sv
// cheri_lsu_arb: shares the load/store unit between the core pipeline and the
// TBRE revocation engine.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   core_* / tbre_*            - request sources (req, we, is_cap, addr, wdata)
//   lsu_*_o                    - muxed request towards the LSU
//   lsu_req_done_i             - LSU accepted the current request
//   lsu_resp_valid_i/_err_i    - LSU response
//   core/tbre_req_done_o       - per-requester acceptance pulses
//   core/tbre_resp_valid_o     - routed response valid
//   resp_err_o                 - response error pass-through
//   tbre_resp_is_wr_o          - routed TBRE response belongs to a write
//   snoop_*                    - core-owned acceptances for TBRE collision checks
//   arb_busy_o                 - not idle, or responses still outstanding
import cheri_pkg::*;

module cheri_lsu_arb #(
    parameter int unsigned MaxStall = 8,
    parameter int unsigned OsDepth  = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic        core_is_cap_i,
    input  logic [31:0] core_addr_i,
    input  logic [32:0] core_wdata_i,
    input  logic        tbre_req_i,
    input  logic        tbre_we_i,
    input  logic        tbre_is_cap_i,
    input  logic [31:0] tbre_addr_i,
    input  logic [32:0] tbre_wdata_i,
    output logic        lsu_req_o,
    output logic        lsu_we_o,
    output logic        lsu_is_cap_o,
    output logic [31:0] lsu_addr_o,
    output logic [32:0] lsu_wdata_o,
    input  logic        lsu_req_done_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    output logic        core_req_done_o,
    output logic        tbre_req_done_o,
    output logic        core_resp_valid_o,
    output logic        tbre_resp_valid_o,
    output logic        resp_err_o,
    output logic        tbre_resp_is_wr_o,
    output logic        snoop_req_done_o,
    output logic        snoop_we_o,
    output logic [31:0] snoop_addr_o,
    output logic        arb_busy_o
);

    localparam int unsigned CntW = $clog2(MaxStall + 1);

    arb_fsm_t        state_q, state_d;
    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;

    logic     fifo_full;
    logic     fifo_empty;
    arb_tag_t fifo_head;
    arb_tag_t push_tag;
    logic     pop;
    logic     space;
    logic     stall_at_max;
    logic     sel_tbre;
    logic     owner_core;
    logic     owner_tbre;
    logic     owner_req;
    logic     req;
    logic     acc;

    assign pop          = lsu_resp_valid_i && !fifo_empty;
    assign space        = !fifo_full || pop;
    assign stall_at_max = (stall_cnt_q >= CntW'(MaxStall));
    assign sel_tbre     = tbre_req_i && (!core_req_i || stall_at_max);

    // Ownership: chosen combinationally in IDLE (zero-latency forwarding),
    // locked in CORE/TBRE until acceptance or withdrawal.
    always_comb begin
        owner_core = 1'b0;
        owner_tbre = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (space) begin
                    if (sel_tbre) begin
                        owner_tbre = 1'b1;
                    end else if (core_req_i) begin
                        owner_core = 1'b1;
                    end
                end
            end
            ARB_CORE: owner_core = 1'b1;
            ARB_TBRE: owner_tbre = 1'b1;
            default: ;
        endcase
    end

    assign owner_req = (owner_core && core_req_i) || (owner_tbre && tbre_req_i);
    assign req       = owner_req && space;
    assign acc       = req && lsu_req_done_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (req && !lsu_req_done_i) begin
                    state_d = owner_tbre ? ARB_TBRE : ARB_CORE;
                end
            end
            ARB_CORE, ARB_TBRE: begin
                if (acc || !owner_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!tbre_req_i || (acc && owner_tbre)) begin
            stall_cnt_d = '0;
        end else if (!owner_tbre && !stall_at_max) begin
            stall_cnt_d = stall_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ARB_IDLE;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        push_tag            = '0;
        push_tag.owner_tbre = owner_tbre;
        push_tag.we         = owner_tbre ? tbre_we_i : core_we_i;
    end

    cheri_arb_tag_fifo #(
        .Depth (OsDepth)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (acc),
        .data_i  (push_tag),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // Outputs are forced low while reset is held, since IDLE forwards
    // requester inputs combinationally.
    always_comb begin
        lsu_req_o         = req;
        lsu_we_o          = 1'b0;
        lsu_is_cap_o      = 1'b0;
        lsu_addr_o        = '0;
        lsu_wdata_o       = '0;
        snoop_we_o        = 1'b0;
        snoop_addr_o      = '0;
        if (owner_core) begin
            lsu_we_o     = core_we_i;
            lsu_is_cap_o = core_is_cap_i;
            lsu_addr_o   = core_addr_i;
            lsu_wdata_o  = core_wdata_i;
            snoop_we_o   = core_we_i;
            snoop_addr_o = core_addr_i;
        end else if (owner_tbre) begin
            lsu_we_o     = tbre_we_i;
            lsu_is_cap_o = tbre_is_cap_i;
            lsu_addr_o   = tbre_addr_i;
            lsu_wdata_o  = tbre_wdata_i;
        end
        core_req_done_o   = acc && owner_core;
        tbre_req_done_o   = acc && owner_tbre;
        snoop_req_done_o  = acc && owner_core;
        core_resp_valid_o = pop && !fifo_head.owner_tbre;
        tbre_resp_valid_o = pop && fifo_head.owner_tbre;
        tbre_resp_is_wr_o = pop && fifo_head.owner_tbre && fifo_head.we;
        resp_err_o        = lsu_resp_err_i;
        arb_busy_o        = (state_q != ARB_IDLE) || !fifo_empty;
        if (!rst_ni) begin
            lsu_req_o         = 1'b0;
            lsu_we_o          = 1'b0;
            lsu_is_cap_o      = 1'b0;
            lsu_addr_o        = '0;
            lsu_wdata_o       = '0;
            snoop_we_o        = 1'b0;
            snoop_addr_o      = '0;
            core_req_done_o   = 1'b0;
            tbre_req_done_o   = 1'b0;
            snoop_req_done_o  = 1'b0;
            core_resp_valid_o = 1'b0;
            tbre_resp_valid_o = 1'b0;
            tbre_resp_is_wr_o = 1'b0;
            resp_err_o        = 1'b0;
            arb_busy_o        = 1'b0;
        end
    end

endmodule
